paddle_input_conditioner: RTL and testbench

//  Feeds the four paddle timers (PDL0-PDL3, $C064-$C067). Converts MiSTer signed analog joystick

---
 rtl/paddle_input_conditioner.sv | 105 ++++++++++
 tb/tb_paddle_input_conditioner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_conditioner.sv
// Signed analog stick axes -> held 0..255 paddle values (deadzone, inversion, IIR smoothing).
// Filter passes every SAMPLE_DIV cycles; outputs freeze while trigger or the channel's timer is active.
module paddle_input_conditioner #(
  parameter int SAMPLE_DIV   = 14318,
  parameter int FILTER_SHIFT = 2,
  parameter int DEADZONE     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy_a0,
  input  logic [15:0] joy_a1,
  input  logic [3:0]  invert,
  input  logic        trigger,
  input  logic [3:0]  timer_busy,
  output logic [7:0]  paddle0,
  output logic [7:0]  paddle1,
  output logic [7:0]  paddle2,
  output logic [7:0]  paddle3,
  output logic        sample_stb
);

  localparam int AW = 8 + FILTER_SHIFT;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  if (SAMPLE_DIV < 5) begin : g_div_check
    $error("paddle_input_conditioner: SAMPLE_DIV must be at least 5");
  end

  typedef enum logic [2:0] {S_IDLE, S_CH0, S_CH1, S_CH2, S_CH3} state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q;
  state_t        state_q;
  logic [AW-1:0] acc_q    [4];
  logic [AW-1:0] acc_d    [4];
  logic [7:0]    axis     [4];
  logic [7:0]    u        [4];
  logic [7:0]    filt     [4];
  logic [7:0]    paddle_q [4];

  // Deadzone is judged on the signed magnitude, so -128 counts as 128.
  function automatic logic [7:0] to_unsigned(input logic [7:0] s, input logic inv);
    logic [8:0] sx;
    logic [8:0] mag;
    logic [7:0] r;
    sx  = {s[7], s};
    mag = s[7] ? (9'd0 - sx) : sx;
    r   = (mag < 9'(DEADZONE)) ? 8'd128 : {~s[7], s[6:0]};
    return inv ? ~r : r;
  endfunction

  always_comb begin
    axis[0] = joy_a0[7:0];
    axis[1] = joy_a0[15:8];
    axis[2] = joy_a1[7:0];
    axis[3] = joy_a1[15:8];
    for (int i = 0; i < 4; i++) begin
      u[i]     = to_unsigned(axis[i], invert[i]);
      acc_d[i] = acc_q[i] - (acc_q[i] >> FILTER_SHIFT) + AW'(u[i]);
      filt[i]  = 8'(acc_q[i] >> FILTER_SHIFT);
    end
    cnt_d = (cnt_q == CW'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= (cnt_d == CW'(SAMPLE_DIV - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) acc_q[i] <= AW'(128) << FILTER_SHIFT;
    end else begin
      case (state_q)
        S_IDLE: if (stb_q) state_q <= S_CH0;
        S_CH0: begin acc_q[0] <= acc_d[0]; state_q <= S_CH1; end
        S_CH1: begin acc_q[1] <= acc_d[1]; state_q <= S_CH2; end
        S_CH2: begin acc_q[2] <= acc_d[2]; state_q <= S_CH3; end
        S_CH3: begin acc_q[3] <= acc_d[3]; state_q <= S_IDLE; end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Timers latch the value already on the bus, so the trigger cycle itself must not update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) paddle_q[i] <= 8'd128;
      else if (!trigger && !timer_busy[i]) paddle_q[i] <= filt[i];
    end
  end

  assign paddle0    = paddle_q[0];
  assign paddle1    = paddle_q[1];
  assign paddle2    = paddle_q[2];
  assign paddle3    = paddle_q[3];
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner: an unfiltered (k=0) and a filtered (k=2) instance share stimulus.
// Expected paddle values come from a behavioural axis/IIR model and are queued per filter pass.
module tb_paddle_input_conditioner;

  localparam int DIV = 20;
  localparam int DZ  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] joy_a0, joy_a1;
  logic [3:0]  invert, timer_busy;
  logic        trigger;
  logic [7:0]  pk0 [4];
  logic [7:0]  pk2 [4];
  logic        stb0, stb2;

  always #5 clk = ~clk;

  paddle_input_conditioner #(.SAMPLE_DIV(DIV), .FILTER_SHIFT(0), .DEADZONE(DZ)) u_k0 (
    .clk(clk), .reset(reset), .joy_a0(joy_a0), .joy_a1(joy_a1), .invert(invert),
    .trigger(trigger), .timer_busy(timer_busy),
    .paddle0(pk0[0]), .paddle1(pk0[1]), .paddle2(pk0[2]), .paddle3(pk0[3]), .sample_stb(stb0));

  paddle_input_conditioner #(.SAMPLE_DIV(DIV), .FILTER_SHIFT(2), .DEADZONE(DZ)) u_k2 (
    .clk(clk), .reset(reset), .joy_a0(joy_a0), .joy_a1(joy_a1), .invert(invert),
    .trigger(trigger), .timer_busy(timer_busy),
    .paddle0(pk2[0]), .paddle1(pk2[1]), .paddle2(pk2[2]), .paddle3(pk2[3]), .sample_stb(stb2));

  typedef struct {
    string tag;
    int    dut;
    int    ch;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   acc2 [4];
  int   filt [2][4];
  int   pad  [2][4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int conv(input logic [7:0] s, input logic inv);
    int v;
    int r;
    v = $signed(s);
    if (v > -DZ && v < DZ) r = 128;
    else r = v + 128;
    if (inv) r = 255 - r;
    return r;
  endfunction

  function automatic logic [7:0] axis(input int i);
    case (i)
      0:       return joy_a0[7:0];
      1:       return joy_a0[15:8];
      2:       return joy_a1[7:0];
      default: return joy_a1[15:8];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      acc2[i] = 512;
      for (int d = 0; d < 2; d++) begin
        filt[d][i] = 128;
        pad[d][i]  = 128;
      end
    end
  endtask

  task automatic model_update();
    int uv;
    for (int i = 0; i < 4; i++) begin
      uv = conv(axis(i), invert[i]);
      acc2[i] = acc2[i] - (acc2[i] / 4) + uv;
      filt[0][i] = uv;
      filt[1][i] = acc2[i] / 4;
    end
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (!trigger && !timer_busy[i]) pad[d][i] = filt[d][i];
        e.tag = tag;
        e.dut = d;
        e.ch  = i;
        e.val = pad[d][i];
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_sb();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = (e.dut == 0) ? pk0[e.ch] : pk2[e.ch];
      ncmp++;
      assert (obs === 8'(e.val)) else begin
        nfail++;
        $error("FAIL %s k%0d paddle%0d observed=%0d expected=%0d", e.tag, e.dut * 2, e.ch, obs, e.val);
      end
    end
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    while (stb0 !== 1'b1 && n < 3 * DIV) begin
      step();
      n++;
    end
    ncmp++;
    assert (stb0 === 1'b1 && stb2 === 1'b1) else begin
      nfail++;
      $error("FAIL stb_wait observed stb0=%b stb2=%b after %0d cycles expected both 1", stb0, stb2, n);
    end
  endtask

  // Strobe cycle -> CH0..CH3 -> last paddle register: six edges after the strobe is seen.
  task automatic run_pass(input string tag);
    model_update();
    push_expect(tag);
    wait_stb();
    repeat (6) step();
    check_sb();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    step();
    model_reset();
    push_expect(tag);
    check_sb();
    chk({tag, "_stb_k0"}, 32'(stb0), 0);
    chk({tag, "_stb_k2"}, 32'(stb2), 0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int first;
    reset = 1'b1; joy_a0 = '0; joy_a1 = '0; invert = '0; trigger = 1'b0; timer_busy = '0;
    model_reset();

    do_reset("reset");

    // Full-scale axes and the CH1 -> paddle1 latency
    joy_a0 = 16'h7F80;
    model_update();
    push_expect("t1");
    wait_stb();
    repeat (3) step();
    chk("t1_p0_after_ch0", 32'(pk0[0]), 0);
    chk("t1_p1_before", 32'(pk0[1]), 128);
    step();
    chk("t1_p1_after_ch1", 32'(pk0[1]), 255);
    repeat (2) step();
    check_sb();

    // Deadzone edges
    joy_a0[7:0] = 8'd3;   run_pass("t2_x3");  chk("t2_x3_p0", 32'(pk0[0]), 128);
    joy_a0[7:0] = 8'd4;   run_pass("t2_x4");  chk("t2_x4_p0", 32'(pk0[0]), 132);
    joy_a0[7:0] = 8'hFC;  run_pass("t2_xm4"); chk("t2_xm4_p0", 32'(pk0[0]), 124);

    // IIR step response from centre
    do_reset("reset2");
    joy_a0 = 16'h7F7F;
    run_pass("t3");
    chk("t3_first_pass", 32'(pk2[0]), 159);
    prev = pk2[0];
    for (int p = 0; p < 15; p++) begin
      run_pass("t3_step");
      chk("t3_rising", 32'(pk2[0] >= prev), 1);
      prev = pk2[0];
    end
    chk("t3_reach_250", 32'(pk2[0] >= 250), 1);

    // Hold while trigger / timer busy
    joy_a1 = 16'h0048;
    run_pass("t4_settle");
    chk("t4_settle_p2", 32'(pk0[2]), 200);
    joy_a1[7:0] = 8'hB2;
    trigger = 1'b1;
    timer_busy = 4'b0100;
    for (int p = 0; p < 150; p++) begin
      run_pass("t4_hold");
      chk("t4_held_p2", 32'(pk0[2]), 200);
    end
    trigger = 1'b0;
    step();
    push_expect("t4_trig_off");
    check_sb();
    chk("t4_busy_hold_p2", 32'(pk0[2]), 200);
    timer_busy = 4'b0000;
    step();
    push_expect("t4_release");
    check_sb();
    chk("t4_release_p2", 32'(pk0[2]), 50);

    // Per-axis inversion
    invert = 4'b1000;
    joy_a1 = 16'h7FB2;
    run_pass("t5");
    chk("t5_p3_inverted", 32'(pk0[3]), 0);
    chk("t5_p2_untouched", 32'(pk0[2]), 50);

    // Reset in the middle of a pass
    wait_stb();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    push_expect("t6_reset");
    check_sb();
    chk("t6_stb_low", 32'(stb0), 0);
    first = 0;
    for (int c = 1; c <= 3 * DIV; c++) begin
      if (stb0 === 1'b1) begin
        first = c;
        break;
      end
      step();
    end
    chk("t6_first_stb_cycle", 32'(first), 32'(DIV));
    push_expect("t6_idle");
    check_sb();
    run_pass("t6_after");
    chk("t6_after_p3", 32'(pk0[3]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
